// File: rtl/display_pkg.sv
// Shared display timing constants.
//   COORD_W      : width of the signed raster coordinates
//   *_720        : 1280x720 @ 60 Hz (74.25 MHz pixel clock)
//   *_1080       : 1920x1080 @ 60 Hz (148.5 MHz pixel clock)
//   *_480        : 640x480 @ 60 Hz (25.175 MHz pixel clock)
//   axis_sta()   : first (most negative) coordinate of an axis, where
//                  blanking is encoded as negative positions.
package display_pkg;

  localparam int COORD_W = 16;

  typedef logic signed [COORD_W-1:0] coord_t;

  // 1280x720
  localparam int   H_RES_720  = 1280;
  localparam int   H_FP_720   = 110;
  localparam int   H_SYNC_720 = 40;
  localparam int   H_BP_720   = 220;
  localparam int   V_RES_720  = 720;
  localparam int   V_FP_720   = 5;
  localparam int   V_SYNC_720 = 5;
  localparam int   V_BP_720   = 20;
  localparam logic H_POL_720  = 1'b1;
  localparam logic V_POL_720  = 1'b1;

  // 1920x1080
  localparam int   H_RES_1080  = 1920;
  localparam int   H_FP_1080   = 88;
  localparam int   H_SYNC_1080 = 44;
  localparam int   H_BP_1080   = 148;
  localparam int   V_RES_1080  = 1080;
  localparam int   V_FP_1080   = 4;
  localparam int   V_SYNC_1080 = 5;
  localparam int   V_BP_1080   = 36;
  localparam logic H_POL_1080  = 1'b1;
  localparam logic V_POL_1080  = 1'b1;

  // 640x480
  localparam int   H_RES_480  = 640;
  localparam int   H_FP_480   = 16;
  localparam int   H_SYNC_480 = 96;
  localparam int   H_BP_480   = 48;
  localparam int   V_RES_480  = 480;
  localparam int   V_FP_480   = 10;
  localparam int   V_SYNC_480 = 2;
  localparam int   V_BP_480   = 33;
  localparam logic H_POL_480  = 1'b0;
  localparam logic V_POL_480  = 1'b0;

  function automatic coord_t axis_sta(input int fp, input int sync, input int bp);
    return coord_t'(-(fp + sync + bp));
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a signed position counter running STA..END.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   adv_i        : advance enable (always 1 for x, x-wrap for y)
//   pos_o        : registered position
//   sync_o       : registered sync level (POL inside SYNC_BEG..SYNC_END)
//   active_d_o   : next position is in the active region (>= 0)
//   start_d_o    : next position is STA
// The two *_d_o flags describe the position about to be loaded, so the
// parent can register its combined decodes in step with pos_o.
module timing_axis
  import display_pkg::*;
#(
  parameter coord_t STA      = axis_sta(H_FP_720, H_SYNC_720, H_BP_720),
  parameter coord_t END      = coord_t'(H_RES_720 - 1),
  parameter coord_t SYNC_BEG = coord_t'(-(H_SYNC_720 + H_BP_720)),
  parameter coord_t SYNC_END = coord_t'(-H_BP_720 - 1),
  parameter logic   POL      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv_i,
  output logic signed [COORD_W-1:0] pos_o,
  output logic                      sync_o,
  output logic                      active_d_o,
  output logic                      start_d_o
);

  coord_t pos_q, pos_d;
  logic   sync_q, sync_d;

  // NOTE: every signal driven here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    pos_d = pos_q;
    if (adv_i) begin
      if (pos_q == END) pos_d = STA;
      else              pos_d = pos_q + coord_t'(1);
    end
  end

  assign sync_d     = (pos_d >= SYNC_BEG && pos_d <= SYNC_END) ? POL : ~POL;
  assign active_d_o = ~pos_d[COORD_W-1];
  assign start_d_o  = (pos_d == STA);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= STA;
      sync_q <= ~POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos_o  = pos_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/display_timings.sv
// Raster position and sync/enable generator (default 1280x720 @ 60 Hz).
//   clk, rst  : pixel clock, asynchronous active-high reset
//   o_sx/o_sy : signed position; blanking is negative, active is 0..RES-1
//   o_hsync   : H_POL while x is in the horizontal sync region
//   o_vsync   : V_POL for whole lines while y is in the vertical sync region
//   o_de      : active video (x >= 0 and y >= 0)
//   o_line    : one-cycle strobe at the first position of every line
//   o_frame   : one-cycle strobe at the first position of every frame
// All outputs are flops decoded from the next position, so they are
// coherent with o_sx/o_sy in the same cycle.
module display_timings
  import display_pkg::*;
#(
  parameter int   H_RES  = H_RES_720,
  parameter int   H_FP   = H_FP_720,
  parameter int   H_SYNC = H_SYNC_720,
  parameter int   H_BP   = H_BP_720,
  parameter int   V_RES  = V_RES_720,
  parameter int   V_FP   = V_FP_720,
  parameter int   V_SYNC = V_SYNC_720,
  parameter int   V_BP   = V_BP_720,
  parameter logic H_POL  = H_POL_720,
  parameter logic V_POL  = V_POL_720
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic signed [COORD_W-1:0] o_sx,
  output logic signed [COORD_W-1:0] o_sy,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_de,
  output logic                      o_line,
  output logic                      o_frame
);

  localparam coord_t H_STA      = axis_sta(H_FP, H_SYNC, H_BP);
  localparam coord_t H_END      = coord_t'(H_RES - 1);
  localparam coord_t H_SYNC_BEG = coord_t'(int'(H_STA) + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(int'(H_STA) + H_FP + H_SYNC - 1);
  localparam coord_t V_STA      = axis_sta(V_FP, V_SYNC, V_BP);
  localparam coord_t V_END      = coord_t'(V_RES - 1);
  localparam coord_t V_SYNC_BEG = coord_t'(int'(V_STA) + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(int'(V_STA) + V_FP + V_SYNC - 1);

  coord_t sx, sy;
  logic   v_adv;
  logic   h_active_d, h_start_d, v_active_d, v_start_d;
  logic   de_q, line_q, frame_q;

  // y steps on the same edge that x wraps back to H_STA.
  assign v_adv = (sx == H_END);

  timing_axis #(
    .STA(H_STA), .END(H_END), .SYNC_BEG(H_SYNC_BEG), .SYNC_END(H_SYNC_END), .POL(H_POL)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .adv_i      (1'b1),
    .pos_o      (sx),
    .sync_o     (o_hsync),
    .active_d_o (h_active_d),
    .start_d_o  (h_start_d)
  );

  timing_axis #(
    .STA(V_STA), .END(V_END), .SYNC_BEG(V_SYNC_BEG), .SYNC_END(V_SYNC_END), .POL(V_POL)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .adv_i      (v_adv),
    .pos_o      (sy),
    .sync_o     (o_vsync),
    .active_d_o (v_active_d),
    .start_d_o  (v_start_d)
  );

  // The reset state shows (H_STA, V_STA) with the strobes low; the strobes
  // only fire when that position is reached by counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      de_q    <= h_active_d & v_active_d;
      line_q  <= h_start_d;
      frame_q <= h_start_d & v_start_d;
    end
  end

  assign o_sx    = sx;
  assign o_sy    = sy;
  assign o_de    = de_q;
  assign o_line  = line_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_display_timings.sv
// Testbench for display_timings: a default 720p instance checked with
// constant vectors and hand-written sequences, plus two small-raster
// instances (normal and inverted sync polarity) checked against an
// arithmetic model under random asynchronous resets.
module tb_display_timings;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;  // posedges since reset release

  // Small raster: 28 cycles/line, 13 lines/frame.
  localparam int S_HRES = 16, S_HFP = 3, S_HSYNC = 4, S_HBP = 5;
  localparam int S_VRES = 6,  S_VFP = 2, S_VSYNC = 2, S_VBP = 3;
  localparam int S_HTOT  = S_HRES + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VTOT  = S_VRES + S_VFP + S_VSYNC + S_VBP;
  localparam int S_FRAME = S_HTOT * S_VTOT;
  localparam int S_HSTA  = -(S_HFP + S_HSYNC + S_HBP);
  localparam int S_VSTA  = -(S_VFP + S_VSYNC + S_VBP);

  logic signed [15:0] d_sx, d_sy, s_sx, s_sy, n_sx, n_sy;
  logic d_hs, d_vs, d_de, d_ln, d_fr;
  logic s_hs, s_vs, s_de, s_ln, s_fr;
  logic n_hs, n_vs, n_de, n_ln, n_fr;
  logic [36:0] d_vec, s_vec, n_vec;

  assign d_vec = {d_sx, d_sy, d_hs, d_vs, d_de, d_ln, d_fr};
  assign s_vec = {s_sx, s_sy, s_hs, s_vs, s_de, s_ln, s_fr};
  assign n_vec = {n_sx, n_sy, n_hs, n_vs, n_de, n_ln, n_fr};

  display_timings dut_d (
    .clk(clk), .rst(rst), .o_sx(d_sx), .o_sy(d_sy), .o_hsync(d_hs),
    .o_vsync(d_vs), .o_de(d_de), .o_line(d_ln), .o_frame(d_fr)
  );

  display_timings #(
    .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .o_sx(s_sx), .o_sy(s_sy), .o_hsync(s_hs),
    .o_vsync(s_vs), .o_de(s_de), .o_line(s_ln), .o_frame(s_fr)
  );

  display_timings #(
    .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .o_sx(n_sx), .o_sy(n_sy), .o_hsync(n_hs),
    .o_vsync(n_vs), .o_de(n_de), .o_line(n_ln), .o_frame(n_fr)
  );

  function automatic logic [36:0] vec(input int sx, input int sy, input logic hs,
                                      input logic vs, input logic de, input logic ln,
                                      input logic fr);
    return {16'(sx), 16'(sy), hs, vs, de, ln, fr};
  endfunction

  // Small-raster model: position is the cycle count folded into a frame.
  function automatic logic [36:0] model(input int tc, input logic hp, input logic vp);
    int p, x, y;
    logic hs, vs, de, ln, fr;
    if (tc == 0) return vec(S_HSTA, S_VSTA, ~hp, ~vp, 1'b0, 1'b0, 1'b0);
    p  = tc % S_FRAME;
    x  = S_HSTA + p % S_HTOT;
    y  = S_VSTA + p / S_HTOT;
    hs = (x >= S_HSTA + S_HFP && x < S_HSTA + S_HFP + S_HSYNC) ? hp : ~hp;
    vs = (y >= S_VSTA + S_VFP && y < S_VSTA + S_VFP + S_VSYNC) ? vp : ~vp;
    de = (x >= 0) && (y >= 0);
    ln = (x == S_HSTA);
    fr = ln && (y == S_VSTA);
    return vec(x, y, hs, vs, de, ln, fr);
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    logic [36:0] a, e;
    a = act;
    e = exp;
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0d: got (%0d,%0d) hs=%b vs=%b de=%b ln=%b fr=%b, want (%0d,%0d) hs=%b vs=%b de=%b ln=%b fr=%b",
                  name, t, $signed(a[36:21]), $signed(a[20:5]), a[4], a[3], a[2], a[1], a[0],
                  $signed(e[36:21]), $signed(e[20:5]), e[4], e[3], e[2], e[1], e[0]);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Reset for a few cycles, release on a falling edge; t=0 is the reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
  endtask

  task automatic step_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  typedef struct {
    int          t;
    logic [36:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int hs_cnt, hs_first, hs_last, ln_first, ln_sx, ln_sy;
    int fr1, fr2, fr_cnt, de_cnt, vs_cnt, vsn_cnt;

    tbl[0]  = '{0,     vec(-370, -30, 0, 0, 0, 0, 0), "release_t0"};
    tbl[1]  = '{1,     vec(-369, -30, 0, 0, 0, 0, 0), "first_edge"};
    tbl[2]  = '{109,   vec(-261, -30, 0, 0, 0, 0, 0), "before_hsync"};
    tbl[3]  = '{110,   vec(-260, -30, 1, 0, 0, 0, 0), "hsync_start"};
    tbl[4]  = '{149,   vec(-221, -30, 1, 0, 0, 0, 0), "hsync_last"};
    tbl[5]  = '{150,   vec(-220, -30, 0, 0, 0, 0, 0), "hsync_end"};
    tbl[6]  = '{1649,  vec(1279, -30, 0, 0, 0, 0, 0), "line0_end"};
    tbl[7]  = '{1650,  vec(-370, -29, 0, 0, 0, 1, 0), "line1_start"};
    tbl[8]  = '{8249,  vec(1279, -26, 0, 0, 0, 0, 0), "before_vsync"};
    tbl[9]  = '{8250,  vec(-370, -25, 0, 1, 0, 1, 0), "vsync_start"};
    tbl[10] = '{8260,  vec(-360, -25, 0, 1, 0, 0, 0), "vsync_mid"};
    tbl[11] = '{16499, vec(1279, -21, 0, 1, 0, 0, 0), "vsync_last"};
    tbl[12] = '{16500, vec(-370, -20, 0, 0, 0, 1, 0), "vsync_end"};
    tbl[13] = '{49500, vec(-370, 0, 0, 0, 0, 1, 0),   "active_line0"};
    tbl[14] = '{49869, vec(-1, 0, 0, 0, 0, 0, 0),     "before_de"};
    tbl[15] = '{49870, vec(0, 0, 0, 0, 1, 0, 0),      "first_pixel"};
    tbl[16] = '{51149, vec(1279, 0, 0, 0, 1, 0, 0),   "last_pixel_l0"};
    tbl[17] = '{51150, vec(-370, 1, 0, 0, 0, 1, 0),   "active_line1"};

    // Reset held from time zero, sampled after a clock edge.
    #12;
    check("reset_hold_720", d_vec, vec(-370, -30, 0, 0, 0, 0, 0));
    check("reset_hold_s",   s_vec, model(0, 1'b1, 1'b1));
    check("reset_hold_n",   n_vec, model(0, 1'b0, 1'b0));

    // First line: hsync window and line strobe.
    do_reset();
    hs_cnt = 0; hs_first = 0; hs_last = 0; ln_first = -1; ln_sx = 0; ln_sy = 0;
    while (t < 1650) begin
      @(negedge clk);
      t++;
      if (d_hs) begin
        if (hs_cnt == 0) hs_first = d_sx;
        hs_last = d_sx;
        hs_cnt++;
      end
      if (d_ln && ln_first < 0) begin
        ln_first = t;
        ln_sx    = d_sx;
        ln_sy    = d_sy;
      end
    end
    check_int("hsync_cycles",  hs_cnt,   40);
    check_int("hsync_first_x", hs_first, -260);
    check_int("hsync_last_x",  hs_last,  -221);
    check_int("line_first_t",  ln_first, 1650);
    check_int("line_sx",       ln_sx,    -370);
    check_int("line_sy",       ln_sy,    -29);

    // Constant vectors along the 720p raster.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step_to(tbl[i].t);
      check(tbl[i].name, d_vec, tbl[i].exp);
    end

    // Asynchronous reset in the middle of vsync.
    do_reset();
    step_to(12020);
    check("mid_vsync_pos", d_vec, vec(100, -23, 0, 1, 0, 0, 0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", d_vec, vec(-370, -30, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    check("post_async_t0", d_vec, vec(-370, -30, 0, 0, 0, 0, 0));
    step_to(1);
    check("post_async_t1", d_vec, vec(-369, -30, 0, 0, 0, 0, 0));
    step_to(1650);
    check("post_async_line", d_vec, vec(-370, -29, 0, 0, 0, 1, 0));

    // Two full small frames: strobes, de and vsync totals, corner wrap.
    do_reset();
    fr1 = -1; fr2 = -1; fr_cnt = 0; de_cnt = 0; vs_cnt = 0; vsn_cnt = 0;
    while (t < 2 * S_FRAME) begin
      @(negedge clk);
      t++;
      if (s_fr) begin
        fr_cnt++;
        if (fr1 < 0) fr1 = t;
        else if (fr2 < 0) fr2 = t;
      end
      if (t <= S_FRAME) begin
        if (s_de) de_cnt++;
        if (s_vs) vs_cnt++;
        if (!n_vs) vsn_cnt++;
      end
      if (t == S_FRAME - 1) check("corner_last", s_vec, vec(S_HRES - 1, S_VRES - 1, 0, 0, 1, 0, 0));
      if (t == S_FRAME)     check("corner_wrap", s_vec, vec(S_HSTA, S_VSTA, 0, 0, 0, 1, 1));
    end
    check_int("frame_count",   fr_cnt,  2);
    check_int("frame1_t",      fr1,     S_FRAME);
    check_int("frame2_t",      fr2,     2 * S_FRAME);
    check_int("de_per_frame",  de_cnt,  S_HRES * S_VRES);
    check_int("vsync_cycles",  vs_cnt,  S_VSYNC * S_HTOT);
    check_int("vsync_n_cycles", vsn_cnt, S_VSYNC * S_HTOT);

    // Random asynchronous resets against the model, both polarities.
    do_reset();
    check("rand_t0_s", s_vec, model(t, 1'b1, 1'b1));
    check("rand_t0_n", n_vec, model(t, 1'b0, 1'b0));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) t = 0;
      else     t++;
      check("rand_s", s_vec, model(t, 1'b1, 1'b1));
      check("rand_n", n_vec, model(t, 1'b0, 1'b0));
      if (rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        t = 0;
        check("rand_async_s", s_vec, model(0, 1'b1, 1'b1));
        check("rand_async_n", n_vec, model(0, 1'b0, 1'b0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
